memory_burst: RTL and testbench

- Parametrised main-memory model that is the next generation of the single-word `memory` block behind the L2 cache.
- Adds configurable data/address width, depth and access latency.
- Adds a cache-line burst mode with critical-word-first wrap.
- Replaces the shared inout data bus with split write/read buses plus an explicit beat strobe.
- Serves L2 line refills and write-backs.

---
 rtl/memory_burst.sv | 136 +++++++++++++
 tb/tb_memory_burst.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_burst.sv
// Parametrised main-memory model behind the L2: single-word or BURST_LEN-word
// transfers with critical-word-first wrap inside the aligned line, after LATENCY wait cycles.
module memory_burst #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 23,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              ce,
  input  logic              rw,
  input  logic              burst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              beat,
  output logic              rdy,
  output logic              busy
);

  localparam int BOFF  = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LW    = $clog2(BURST_LEN);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Handshake: a request is accepted at an edge where state==IDLE, cs=1 and ce=1;
  // there is no backpressure. Each cycle with beat=1 is one transfer (read data on
  // rdata, write data taken from wdata at the edge ending that cycle); rdy marks the last.
  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  // Kept as a plain named register so checkers can bind to it directly.
  state_t state;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [IDX_W-1:0] w0;
  logic             rw_q;
  logic             burst_q;
  logic [LW-1:0]    k;
  logic [CNT_W-1:0] cnt;

  logic [LW-1:0]    last_k;
  logic [IDX_W-1:0] cur_addr;
  logic [IDX_W-1:0] nxt_addr;
  logic [IDX_W-1:0] req_idx;

  function automatic logic [IDX_W-1:0] beat_addr(input logic [IDX_W-1:0] base,
                                                 input logic            b,
                                                 input logic [LW-1:0]   idx);
    logic [IDX_W-1:0] mask;
    mask = IDX_W'(BURST_LEN - 1);
    if (b) return (base & ~mask) | ((base + IDX_W'(idx)) & mask);
    else   return base;
  endfunction

  // Upper address bits beyond DEPTH alias silently.
  assign req_idx  = IDX_W'(addr >> BOFF);
  assign last_k   = burst_q ? LW'(BURST_LEN - 1) : '0;
  assign cur_addr = beat_addr(w0, burst_q, k);
  assign nxt_addr = beat_addr(w0, burst_q, k + LW'(1));

  always_ff @(posedge clk) begin
    if (!rst && state == XFER && !rw_q) mem[cur_addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata   <= '0;
      beat    <= 1'b0;
      rdy     <= 1'b0;
      busy    <= 1'b0;
      k       <= '0;
      cnt     <= '0;
      w0      <= '0;
      rw_q    <= 1'b0;
      burst_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat <= 1'b0;
          rdy  <= 1'b0;
          if (cs && ce) begin
            w0      <= req_idx;
            rw_q    <= rw;
            burst_q <= burst;
            k       <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            if (LATENCY == 0) begin
              state <= XFER;
              beat  <= 1'b1;
              rdy   <= !burst;
              if (rw) rdata <= mem[req_idx];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(LATENCY - 1)) begin
            state <= XFER;
            beat  <= 1'b1;
            rdy   <= !burst_q;
            if (rw_q) rdata <= mem[w0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        XFER: begin
          if (k == last_k) begin
            state <= IDLE;
            beat  <= 1'b0;
            rdy   <= 1'b0;
            busy  <= 1'b0;
            k     <= '0;
          end else begin
            k   <= k + LW'(1);
            rdy <= ((k + LW'(1)) == last_k);
            if (rw_q) rdata <= mem[nxt_addr];
          end
        end
        default: begin
          state <= IDLE;
          beat  <= 1'b0;
          rdy   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_burst.sv
// Directed bench for memory_burst: default instance (LATENCY=4) and a
// LATENCY=0 / DEPTH=16 instance sharing the input bus, selected by use0.
module tb_memory_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        ce;
  logic        rw;
  logic        burst;
  logic        use0;
  logic [22:0] addr;
  logic [63:0] wdata;

  logic [63:0] rdata_a, rdata_b;
  logic        beat_a, beat_b, rdy_a, rdy_b, busy_a, busy_b;
  logic [63:0] rdata_o;
  logic        beat_o, rdy_o, busy_o;

  always #5 clk = ~clk;

  memory_burst dut (
    .clk(clk), .rst(rst), .cs(cs && !use0), .ce(ce), .rw(rw), .burst(burst),
    .addr(addr), .wdata(wdata), .rdata(rdata_a), .beat(beat_a), .rdy(rdy_a), .busy(busy_a)
  );

  memory_burst #(.LATENCY(0), .DEPTH(16)) dut0 (
    .clk(clk), .rst(rst), .cs(cs && use0), .ce(ce), .rw(rw), .burst(burst),
    .addr(addr), .wdata(wdata), .rdata(rdata_b), .beat(beat_b), .rdy(rdy_b), .busy(busy_b)
  );

  assign rdata_o = use0 ? rdata_b : rdata_a;
  assign beat_o  = use0 ? beat_b  : beat_a;
  assign rdy_o   = use0 ? rdy_b   : rdy_a;
  assign busy_o  = use0 ? busy_b  : busy_a;

  int n_checks;
  int n_pass;

  logic [63:0] wd_v [4];
  logic [63:0] rd_v [4];
  int nb, first_cyc, rdy_k, rdy_cnt, end_cyc;
  logic act;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present a request for one cycle; the accept edge is the next rising edge.
  task automatic req(input logic r, input logic b, input logic [22:0] a);
    @(posedge clk); #1;
    cs = 1'b1; ce = 1'b1; rw = r; burst = b; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; ce = 1'b0;
  endtask

  // Follow a transfer cycle by cycle (cycle 1 = the one after the accept edge)
  // until busy drops; feeds wd_v on write beats and records read beats in rd_v.
  task automatic xfer(input bit pulse);
    nb = 0; first_cyc = -1; rdy_k = -1; rdy_cnt = 0; end_cyc = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (pulse) begin cs = 1'b1; ce = 1'b1; end
      if (rdy_o) begin
        rdy_cnt++;
        rdy_k = beat_o ? nb : -1;
      end
      if (beat_o) begin
        if (nb == 0) first_cyc = cyc;
        if (nb < 4) begin
          rd_v[nb] = rdata_o;
          wdata    = wd_v[nb];
        end
        nb++;
      end
      if (!busy_o) begin
        end_cyc = cyc;
        break;
      end
    end
    if (end_cyc < 0) check("xfer_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; cs = 1'b0; ce = 1'b0; rw = 1'b0; burst = 1'b0;
    addr = '0; wdata = '0; use0 = 1'b0;
    for (int i = 0; i < 4; i++) begin wd_v[i] = '0; rd_v[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_beat", beat_o, 0);
    check("rst_rdy", rdy_o, 0);
    check("rst_rdata", rdata_o, 0);

    // Single write then single read of word 1
    wd_v[0] = 64'h8888888888888888;
    req(1'b0, 1'b0, 23'h000008);
    xfer(1'b0);
    check("t1_wr_first_cyc", first_cyc, 5);
    check("t1_wr_rdy_k", rdy_k, 0);
    check("t1_wr_rdata_hold", rdata_o, 0);
    req(1'b1, 1'b0, 23'h000008);
    xfer(1'b0);
    check("t1_rd_first_cyc", first_cyc, 5);
    check("t1_rd_rdy_k", rdy_k, 0);
    check("t1_rd_data", rd_v[0], 64'h8888888888888888);
    check("t1_rd_busy_fall", end_cyc, 6);
    check("t1_rd_nbeats", nb, 1);

    // Request with cs low is ignored
    @(posedge clk); #1;
    cs = 1'b0; ce = 1'b1; rw = 1'b0; addr = 23'h000008; wdata = 64'h1111111111111111;
    act = 1'b0;
    repeat (8) begin
      @(negedge clk);
      act = act | busy_o | beat_o | rdy_o;
    end
    ce = 1'b0;
    check("t2_no_activity", act, 0);
    req(1'b1, 1'b0, 23'h000008);
    xfer(1'b0);
    check("t2_rd_data", rd_v[0], 64'h8888888888888888);

    // Burst write to line 4..7, burst read starting at word 6 wraps
    wd_v[0] = 64'hA0; wd_v[1] = 64'hA1; wd_v[2] = 64'hA2; wd_v[3] = 64'hA3;
    req(1'b0, 1'b1, 23'h000020);
    xfer(1'b0);
    check("t3_wr_nbeats", nb, 4);
    check("t3_wr_rdy_k", rdy_k, 3);
    req(1'b1, 1'b1, 23'h000030);
    xfer(1'b0);
    check("t3_rd_b0", rd_v[0], 64'hA2);
    check("t3_rd_b1", rd_v[1], 64'hA3);
    check("t3_rd_b2", rd_v[2], 64'hA0);
    check("t3_rd_b3", rd_v[3], 64'hA1);
    check("t3_rd_rdy_k", rdy_k, 3);
    check("t3_rd_rdy_cnt", rdy_cnt, 1);
    check("t3_rd_first_cyc", first_cyc, 5);
    check("t3_rd_busy_fall", end_cyc, 9);

    // ce held high throughout a burst read: exactly one transfer, then the
    // request still present in the idle cycle is accepted
    req(1'b1, 1'b1, 23'h000030);
    xfer(1'b1);
    check("t4_nbeats", nb, 4);
    check("t4_rdy_cnt", rdy_cnt, 1);
    check("t4_b0", rd_v[0], 64'hA2);
    rw = 1'b1; burst = 1'b0; addr = 23'h000028;
    @(posedge clk); #1;
    cs = 1'b0; ce = 1'b0;
    xfer(1'b0);
    check("t4_next_first_cyc", first_cyc, 5);
    check("t4_next_data", rd_v[0], 64'hA1);
    check("t4_next_nbeats", nb, 1);

    // Reset during WAIT aborts the read
    req(1'b1, 1'b0, 23'h000020);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_busy", busy_o, 0);
    check("t5_beat", beat_o, 0);
    check("t5_rdata", rdata_o, 0);
    act = 1'b0;
    repeat (10) begin
      @(negedge clk);
      act = act | busy_o | beat_o | rdy_o;
    end
    check("t5_no_beat", act, 0);
    req(1'b1, 1'b0, 23'h000038);
    xfer(1'b0);
    check("t5_fresh_data", rd_v[0], 64'hA3);

    // LATENCY=0, DEPTH=16 instance: aliasing and line wrap at the top of memory
    use0 = 1'b1;
    wd_v[0] = 64'h55;
    req(1'b0, 1'b0, 23'h000088);
    xfer(1'b0);
    check("t6_wr_first_cyc", first_cyc, 1);
    check("t6_wr_rdy_k", rdy_k, 0);
    check("t6_wr_busy_fall", end_cyc, 2);
    req(1'b1, 1'b0, 23'h000008);
    xfer(1'b0);
    check("t6_rd_first_cyc", first_cyc, 1);
    check("t6_rd_alias", rd_v[0], 64'h55);
    wd_v[0] = 64'hB0; wd_v[1] = 64'hB1; wd_v[2] = 64'hB2; wd_v[3] = 64'hB3;
    req(1'b0, 1'b1, 23'h000078);
    xfer(1'b0);
    check("t6_wr_burst_nbeats", nb, 4);
    req(1'b1, 1'b1, 23'h000060);
    xfer(1'b0);
    check("t6_rd_b0", rd_v[0], 64'hB1);
    check("t6_rd_b1", rd_v[1], 64'hB2);
    check("t6_rd_b2", rd_v[2], 64'hB3);
    check("t6_rd_b3", rd_v[3], 64'hB0);
    check("t6_rd_busy_fall", end_cyc, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
